// File: rtl/hs_rx_ctrl.sv
// Receive side of a 4-phase req/ack handshake from a foreign clock domain.
// Synchronises req, captures the word, offers it on valid/ready, sequences ack, flags stuck senders.

module resync_2 (
    input  logic i_clk,
    input  logic i_nrst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

module hs_rx_ctrl #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic              i_clk,
    input  logic              i_nrst,
    input  logic              i_req,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ack,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_ready,
    output logic              o_err,
    input  logic              i_clr,
    output logic [CNT_W-1:0]  o_count
);

    // One spare bit so the counter can reach TIMEOUT without wrapping.
    localparam int            TW   = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_VALID,
        S_ACK,
        S_RECOVER
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_req_s;
    logic              w_timeout;
    logic [TW-1:0]     r_tcnt;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_count;
    logic              r_err;

    resync_2 u_req_sync (
        .i_clk  (i_clk),
        .i_nrst (i_nrst),
        .i_d    (i_req),
        .o_q    (w_req_s)
    );

    assign w_timeout = (r_tcnt == TLIM);

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // IDLE only leaves on req_s high, and every path back to IDLE requires req_s low,
    // so a single long request can never be captured twice.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_req_s) w_next = S_VALID;
            S_VALID:   if (i_ready) w_next = S_ACK;
            S_ACK: begin
                if (!w_req_s)       w_next = S_IDLE;
                else if (w_timeout) w_next = S_RECOVER;
            end
            S_RECOVER: if (!w_req_s) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_ack   = (r_state == S_ACK);
        o_valid = (r_state == S_VALID);
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_data  <= '0;
            r_tcnt  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_req_s) begin
                r_data <= i_data;
            end
            if (r_state == S_VALID && i_ready) begin
                r_tcnt <= '0;
            end else if (r_state == S_ACK) begin
                r_tcnt <= r_tcnt + 1'b1;
            end
            if (r_state == S_ACK && !w_req_s) begin
                r_count <= r_count + 1'b1;
            end
            // A timeout on the same edge as a clear must leave the flag set.
            if (r_state == S_ACK && w_req_s && w_timeout) begin
                r_err <= 1'b1;
            end else if (i_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign o_data  = r_data;
    assign o_count = r_count;
    assign o_err   = r_err;

endmodule

// File: tb/tb_hs_rx_ctrl.sv
// Directed bench for hs_rx_ctrl: per-cycle comparison against a handshake-level model,
// literal checks at the key latency points, and an in-order scoreboard for a long burst.

module tb_hs_rx_ctrl;

    localparam int TIMEOUT = 16;

    logic       clk;
    logic       nrst;
    logic       req;
    logic [7:0] data;
    logic       ack;
    logic       valid;
    logic [7:0] dataOut;
    logic       ready;
    logic       err;
    logic       clr;
    logic [7:0] count;

    int total;
    int bad;

    hs_rx_ctrl #(
        .DATA_W  (8),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (8)
    ) dut (
        .i_clk   (clk),
        .i_nrst  (nrst),
        .i_req   (req),
        .i_data  (data),
        .o_ack   (ack),
        .o_valid (valid),
        .o_data  (dataOut),
        .i_ready (ready),
        .o_err   (err),
        .i_clr   (clr),
        .o_count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [7:0] d, input logic rdy, input logic c);
        req   = r;
        data  = d;
        ready = rdy;
        clr   = c;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Handshake-level model: req seen two samples late, ack held while the sender
    // keeps req high, giving up after TIMEOUT cycles of ack.
    logic       s1, s2;
    logic       mValid, mAck, mErr, mWaitLow;
    logic [7:0] mData, mCount;
    int         mAge;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            mValid   <= 1'b0;
            mAck     <= 1'b0;
            mErr     <= 1'b0;
            mWaitLow <= 1'b0;
            mData    <= 8'h00;
            mCount   <= 8'h00;
            mAge     <= 0;
        end else begin
            s1 <= req;
            s2 <= s1;
            if (clr) mErr <= 1'b0;
            if (mValid) begin
                if (ready) begin
                    mValid <= 1'b0;
                    mAck   <= 1'b1;
                    mAge   <= 1;
                end
            end else if (mAck) begin
                if (!s2) begin
                    mAck   <= 1'b0;
                    mCount <= mCount + 8'd1;
                end else if (mAge >= TIMEOUT) begin
                    mAck     <= 1'b0;
                    mErr     <= 1'b1;
                    mWaitLow <= 1'b1;
                end else begin
                    mAge <= mAge + 1;
                end
            end else if (mWaitLow) begin
                if (!s2) mWaitLow <= 1'b0;
            end else if (s2) begin
                mValid <= 1'b1;
                mData  <= data;
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("cyc ack",   {31'd0, ack},   {31'd0, mAck});
        checkOutput("cyc valid", {31'd0, valid}, {31'd0, mValid});
        checkOutput("cyc err",   {31'd0, err},   {31'd0, mErr});
        checkOutput("cyc count", {24'd0, count}, {24'd0, mCount});
        if (mValid) checkOutput("cyc data", {24'd0, dataOut}, {24'd0, mData});
    end

    // In-order scoreboard for the burst: an acceptance happens on the edge after a
    // negedge that sees valid and ready together.
    logic [7:0] sentQ[$];
    logic       scbOn;

    always @(negedge clk) begin
        if (scbOn && valid && ready) begin
            if (sentQ.size() == 0) begin
                checkOutput("scb extra word", 32'd1, 32'd0);
            end else begin
                checkOutput("scb word", {24'd0, dataOut}, {24'd0, sentQ[0]});
                sentQ.pop_front();
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit done;
        bit ok;
        total = 0;
        bad   = 0;
        scbOn = 1'b0;
        nrst  = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        tick(2);
        checkOutput("reset ack",   {31'd0, ack},   32'd0);
        checkOutput("reset valid", {31'd0, valid}, 32'd0);
        checkOutput("reset data",  {24'd0, dataOut}, 32'd0);
        checkOutput("reset err",   {31'd0, err},   32'd0);
        checkOutput("reset count", {24'd0, count}, 32'd0);
        nrst = 1'b1;
        tick(2);

        $display("[TB] single transfer");
        applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0);
        tick(2);
        checkOutput("single valid early", {31'd0, valid}, 32'd0);
        tick(1);
        checkOutput("single valid", {31'd0, valid}, 32'd1);
        checkOutput("single data",  {24'd0, dataOut}, 32'hA5);
        checkOutput("single ack early", {31'd0, ack}, 32'd0);
        tick(1);
        checkOutput("single ack", {31'd0, ack}, 32'd1);
        applyStimulus(1'b0, 8'hA5, 1'b1, 1'b0);
        tick(2);
        checkOutput("single ack held", {31'd0, ack}, 32'd1);
        tick(1);
        checkOutput("single ack low", {31'd0, ack}, 32'd0);
        checkOutput("single count", {24'd0, count}, 32'd1);

        $display("[TB] backpressure");
        applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
        tick(3);
        checkOutput("bp valid", {31'd0, valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            checkOutput("bp hold valid", {31'd0, valid}, 32'd1);
            checkOutput("bp hold data",  {24'd0, dataOut}, 32'h3C);
            checkOutput("bp hold ack",   {31'd0, ack}, 32'd0);
        end
        applyStimulus(1'b1, 8'h3C, 1'b1, 1'b0);
        tick(1);
        checkOutput("bp accept valid", {31'd0, valid}, 32'd0);
        checkOutput("bp accept ack",   {31'd0, ack},   32'd1);
        applyStimulus(1'b0, 8'h3C, 1'b0, 1'b0);
        tick(3);
        checkOutput("bp count", {24'd0, count}, 32'd2);

        $display("[TB] timeout");
        applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0);
        tick(4);
        checkOutput("to ack", {31'd0, ack}, 32'd1);
        tick(TIMEOUT - 1);
        checkOutput("to ack last", {31'd0, ack}, 32'd1);
        checkOutput("to err before", {31'd0, err}, 32'd0);
        tick(1);
        checkOutput("to ack drop", {31'd0, ack}, 32'd0);
        checkOutput("to err",      {31'd0, err}, 32'd1);
        checkOutput("to count",    {24'd0, count}, 32'd2);
        tick(5);
        checkOutput("to no recapture", {31'd0, valid}, 32'd0);
        applyStimulus(1'b0, 8'h5A, 1'b0, 1'b0);
        tick(3);
        checkOutput("to err sticky", {31'd0, err}, 32'd1);
        applyStimulus(1'b0, 8'h5A, 1'b0, 1'b1);
        tick(1);
        applyStimulus(1'b0, 8'h5A, 1'b0, 1'b0);
        checkOutput("to err cleared", {31'd0, err}, 32'd0);

        $display("[TB] set vs clear");
        applyStimulus(1'b1, 8'hC3, 1'b1, 1'b0);
        tick(4);
        tick(TIMEOUT - 1);
        applyStimulus(1'b1, 8'hC3, 1'b1, 1'b1);
        tick(1);
        checkOutput("svc err", {31'd0, err}, 32'd1);
        checkOutput("svc ack", {31'd0, ack}, 32'd0);
        applyStimulus(1'b0, 8'hC3, 1'b0, 1'b0);
        tick(3);
        applyStimulus(1'b0, 8'hC3, 1'b0, 1'b1);
        tick(1);
        applyStimulus(1'b0, 8'hC3, 1'b0, 1'b0);
        checkOutput("svc cleared", {31'd0, err}, 32'd0);

        $display("[TB] reset mid ack");
        applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
        tick(4);
        checkOutput("rst pre ack", {31'd0, ack}, 32'd1);
        #2 nrst = 1'b0;
        #1;
        checkOutput("rst ack async",   {31'd0, ack},   32'd0);
        checkOutput("rst valid async", {31'd0, valid}, 32'd0);
        checkOutput("rst count async", {24'd0, count}, 32'd0);
        tick(1);
        nrst = 1'b1;
        tick(2);
        checkOutput("rst recapture early", {31'd0, valid}, 32'd0);
        tick(1);
        checkOutput("rst recapture valid", {31'd0, valid}, 32'd1);
        checkOutput("rst recapture data",  {24'd0, dataOut}, 32'h77);
        tick(1);
        applyStimulus(1'b0, 8'h77, 1'b0, 1'b0);
        tick(3);
        checkOutput("rst done count", {24'd0, count}, 32'd1);

        $display("[TB] back to back");
        nrst = 1'b0;
        tick(1);
        nrst = 1'b1;
        tick(1);
        scbOn = 1'b1;
        done  = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    logic [7:0] w;
                    w = 8'($urandom);
                    sentQ.push_back(w);
                    req  = 1'b1;
                    data = w;
                    ok = 1'b0;
                    for (int c = 0; c < 200 && !ok; c++) begin
                        tick(1);
                        if (ack) ok = 1'b1;
                    end
                    if (!ok) begin
                        checkOutput("b2b ack rise wait", 32'd0, 32'd1);
                        break;
                    end
                    req = 1'b0;
                    ok = 1'b0;
                    for (int c = 0; c < 20 && !ok; c++) begin
                        tick(1);
                        if (!ack) ok = 1'b1;
                    end
                    if (!ok) begin
                        checkOutput("b2b ack fall wait", 32'd0, 32'd1);
                        break;
                    end
                    tick($urandom_range(0, 2));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    tick(1);
                    ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        ready = 1'b0;
        tick(2);
        scbOn = 1'b0;
        checkOutput("b2b count",       {24'd0, count},  32'd44);
        checkOutput("b2b model count", {24'd0, mCount}, 32'd44);
        checkOutput("b2b queue empty", sentQ.size(),    32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hs_rx_ctrl.md
Name: hs_rx_ctrl

Overview:
Receive-side controller for a 4-phase req/ack handshake whose request arrives from a foreign clock domain. It passes i_req through one internal resync_2 instance and samples the unsynchronised data bus only while the synchronised request is high. It then presents the word downstream on a valid/ready interface and sequences the ack back to the sender. It also detects senders that never drop req, using a timeout with a sticky error flag.

Parameters:
DATA_W, 8, width of transferred word
TIMEOUT, 16, max cycles ack may stay high waiting for req_s to fall (>=2)
CNT_W, 8, width of completed-transfer counter

Ports:
i_clk  in  1  clock
i_nrst  in  1  asynchronous active-low reset
i_req  in  1  sender request, asynchronous to i_clk
i_data  in  DATA_W  sender data, asynchronous, stable while req high
o_ack  out  1  acknowledge to sender
o_valid  out  1  o_data holds an unconsumed word
o_data  out  DATA_W  captured word
i_ready  in  1  downstream accepts o_data this cycle
o_err  out  1  sticky timeout flag
i_clr  in  1  clears o_err
o_count  out  CNT_W  completed transfers, wraps modulo 2^CNT_W

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_nrst is asynchronous and active-low.
- Reset values: o_ack=0, o_valid=0, o_data=0, o_err=0, o_count=0, state=IDLE, timeout counter=0. The resync_2 instance is also reset.
- Request synchronisation: req_s is i_req after two i_clk flops (resync_2, same clock and reset). i_data is never synchronised; it is sampled only in IDLE when req_s=1.
- IDLE: o_ack=0.
  - Edge with req_s=1: o_data<=i_data, o_valid<=1, go to VALID.
- VALID: hold o_data and o_valid.
  - Edge with i_ready=1: o_valid<=0, o_ack<=1, timeout counter<=0, go to ACK.
  - req_s falling while in VALID is ignored; the transfer still completes.
- ACK: o_ack=1; timeout counter increments each cycle.
  - Edge with req_s=0: o_ack<=0, o_count<=o_count+1, go to IDLE.
  - Edge with req_s=1 and counter==TIMEOUT-1: o_ack<=0, o_err<=1, go to RECOVER. o_count is not incremented.
  - If req_s=0 on the same edge the counter hits its limit, completion wins (no error).
- RECOVER: o_ack=0.
  - Edge with req_s=0: go to IDLE.
- Re-arming: IDLE always requires a fresh req_s=1 after a low, so one request is never captured twice.
- o_err: set only by the timeout and held until i_clr=1.
  - If set and i_clr occur on the same edge, set wins.
- Throughput: one word per handshake; no buffering beyond the o_data register.
- Latency:
  - i_req high sampled at edge E0 → req_s high after E1 → o_valid high after E2.
  - i_ready high at edge En → o_ack high after En.
  - Sender drops req at edge Em → o_ack low after Em+2.
- Reset mid-transfer: all state returns to reset values immediately. o_ack drops asynchronously. A req still held high by the sender is re-captured as a new transfer once req_s propagates after reset release.
- o_count wraps from 2^CNT_W-1 to 0 without any flag.

Test Plan:
- Single transfer: i_data=0xA5, raise i_req, i_ready=1 → o_valid rises 3 edges after req, o_data=0xA5. o_ack rises the following edge. Drop i_req → o_ack falls 2 edges later, o_count=1.
- Backpressure: i_ready=0 for 10 cycles after o_valid → o_valid and o_data (0x3C) held, o_ack stays 0. On i_ready=1, o_valid falls and o_ack rises the same edge.
- Timeout: TIMEOUT=16, keep i_req high after ack → o_ack falls after 16 cycles, o_err=1, o_count unchanged. No recapture until i_req low then high again. i_clr=1 for one cycle → o_err=0.
- Set-vs-clear: assert i_clr on the exact edge of the timeout → o_err=1 afterwards.
- Back-to-back: 300 transfers with random data and random i_ready gaps → every word received once, in order, and o_count=300 mod 256=44.
- Reset mid-ACK: pull i_nrst low while o_ack=1 → o_ack, o_valid, o_count go to 0 immediately. With i_req still high, release reset → new capture after 3 edges.
